proc_imul_arbiter: RTL and testbench

- Shares one iterative integer multiplier among p_num_reqs requesters (pipeline cores or functional units) using val/rdy handshakes.
- Round-robin arbitration with a sticky grant.
- At most one transaction in flight; the owner is recorded and the response is steered back to it.
- Sits between the processor datapaths' multiplier request/response ports and the shared multiplier instance.

---
 rtl/proc_imul_arbiter.sv | 162 ++++++++++++++++
 tb/tb_proc_imul_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_imul_arbiter.sv
// Round-robin, sticky-grant arbiter sharing one iterative multiplier among p_num_reqs requesters.
// Optional grant/contention statistics are enabled with `define PROC_IMUL_ARB_STATS_EN.
`timescale 1ns/1ps
module proc_imul_arbiter #(
  parameter int p_num_reqs   = 2,
  parameter int p_req_nbits  = 64,
  parameter int p_resp_nbits = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_num_reqs-1:0]             req_val,
  output logic [p_num_reqs-1:0]             req_rdy,
  input  logic [p_num_reqs*p_req_nbits-1:0] req_msg,
  output logic [p_num_reqs-1:0]             resp_val,
  input  logic [p_num_reqs-1:0]             resp_rdy,
  output logic [p_resp_nbits-1:0]           resp_msg,
  output logic                              mul_req_val,
  input  logic                              mul_req_rdy,
  output logic [p_req_nbits-1:0]            mul_req_msg,
  input  logic                              mul_resp_val,
  output logic                              mul_resp_rdy,
  input  logic [p_resp_nbits-1:0]           mul_resp_msg,
  output logic                              busy,
  output logic [1:0]                        owner
`ifdef PROC_IMUL_ARB_STATS_EN
  ,
  output logic [p_num_reqs*16-1:0]          stat_grants,
  output logic [15:0]                       stat_contention
`endif
);

  localparam int unsigned N = p_num_reqs;

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, WAIT = 2'd2} state_e;

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] rr_q, rr_d;
  logic [1:0] win;
  logic       win_vld;
  logic [1:0] sel;
  logic       sel_vld;
  logic       req_fire;
  logic       resp_fire;

  // Rotating priority scan starting at rr_q.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!win_vld && req_val[(32'(rr_q) + k) % N]) begin
        win     = 2'((32'(rr_q) + k) % N);
        win_vld = 1'b1;
      end
    end
  end

  // Requester presented to the multiplier: fresh winner in IDLE, held owner in GRANT.
  always_comb begin
    sel     = (state_q == IDLE) ? win : owner_q;
    sel_vld = (state_q == IDLE) ? win_vld : (state_q == GRANT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          owner_d = win;
          state_d = req_fire ? WAIT : GRANT;
        end
      end
      GRANT: begin
        if (req_fire) state_d = WAIT;
      end
      WAIT: begin
        if (resp_fire) begin
          state_d = IDLE;
          rr_d    = (32'(owner_q) == N - 1) ? '0 : owner_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_rdy      = '0;
    resp_val     = '0;
    resp_msg     = '0;
    mul_req_val  = 1'b0;
    mul_req_msg  = '0;
    mul_resp_rdy = 1'b0;
    case (state_q)
      IDLE, GRANT: begin
        for (int unsigned i = 0; i < N; i++) begin
          if (sel_vld && i == 32'(sel)) begin
            mul_req_val = req_val[i];
            mul_req_msg = req_msg[i*p_req_nbits +: p_req_nbits];
            req_rdy[i]  = mul_req_rdy;
          end
        end
      end
      WAIT: begin
        for (int unsigned i = 0; i < N; i++) begin
          if (i == 32'(owner_q)) begin
            resp_val[i]  = mul_resp_val;
            mul_resp_rdy = resp_rdy[i];
          end
        end
        resp_msg = mul_resp_msg;
      end
      default: ;
    endcase
  end

  assign req_fire  = mul_req_val & mul_req_rdy;
  assign resp_fire = mul_resp_val & mul_resp_rdy;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

`ifdef PROC_IMUL_ARB_STATS_EN
  logic [15:0] grant_q [p_num_reqs];
  logic [15:0] cont_q;
  logic        contended;

  assign contended = (state_q != WAIT) && ($countones(req_val) > 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N; i++) grant_q[i] <= '0;
      cont_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (req_fire && i == 32'(sel) && grant_q[i] != '1) grant_q[i] <= grant_q[i] + 16'd1;
      end
      if (contended && cont_q != '1) cont_q <= cont_q + 16'd1;
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int unsigned i = 0; i < N; i++) stat_grants[i*16 +: 16] = grant_q[i];
  end

  assign stat_contention = cont_q;
`endif

endmodule

// File: tb/tb_proc_imul_arbiter.sv
// Self-checking bench for proc_imul_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of the arbitration rules and a multiplier stub.
`timescale 1ns/1ps
module tb_proc_imul_arbiter;
  localparam int N  = 2;
  localparam int RW = 64;
  localparam int SW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_val, req_rdy, resp_val, resp_rdy;
  logic [N*RW-1:0] req_msg;
  logic [SW-1:0]   resp_msg;
  logic            mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy;
  logic [RW-1:0]   mul_req_msg;
  logic [SW-1:0]   mul_resp_msg;
  logic            busy;
  logic [1:0]      owner;
`ifdef PROC_IMUL_ARB_STATS_EN
  logic [N*16-1:0] stat_grants;
  logic [15:0]     stat_contention;
`endif

  proc_imul_arbiter #(.p_num_reqs(N), .p_req_nbits(RW), .p_resp_nbits(SW)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
    .mul_req_val(mul_req_val), .mul_req_rdy(mul_req_rdy), .mul_req_msg(mul_req_msg),
    .mul_resp_val(mul_resp_val), .mul_resp_rdy(mul_resp_rdy), .mul_resp_msg(mul_resp_msg),
    .busy(busy), .owner(owner)
`ifdef PROC_IMUL_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_contention(stat_contention)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who holds the grant (-1 = nobody), whether a multiply is outstanding, rotation start.
  int holder = -1;
  bit inflight = 0;
  int rr = 0;
  int m_owner = 0;
  int g_cnt [N];
  int c_cnt = 0;

  int            cand;
  logic [N-1:0]  e_req_rdy, e_resp_val;
  logic          e_mreq_val, e_mresp_rdy;
  logic [RW-1:0] e_mreq_msg;
  logic [SW-1:0] e_resp_msg;

  int            fire_req;
  bit            fire_resp;
  int            fire_owner;
  logic [SW-1:0] fire_resp_msg;

  task automatic model_reset();
    holder = -1; inflight = 0; rr = 0; m_owner = 0; c_cnt = 0;
    for (int i = 0; i < N; i++) g_cnt[i] = 0;
  endtask

  task automatic model_eval();
    e_req_rdy = '0; e_resp_val = '0; e_mreq_val = 1'b0; e_mresp_rdy = 1'b0;
    e_mreq_msg = '0; e_resp_msg = '0; cand = -1;
    if (inflight) begin
      e_resp_val[m_owner] = mul_resp_val;
      e_mresp_rdy = resp_rdy[m_owner];
      e_resp_msg = mul_resp_msg;
    end else begin
      if (holder >= 0) cand = holder;
      else for (int k = 0; k < N; k++) if (cand < 0 && req_val[(rr + k) % N]) cand = (rr + k) % N;
      if (cand >= 0) begin
        e_mreq_val = req_val[cand];
        e_mreq_msg = req_msg[cand*RW +: RW];
        e_req_rdy[cand] = mul_req_rdy;
      end
    end
  endtask

  // One clock cycle: called just after a falling edge with inputs set; returns at the next falling edge.
  task automatic tick();
    #1;
    model_eval();
    chk("req_rdy", req_rdy, e_req_rdy);
    chk("mul_req_val", mul_req_val, e_mreq_val);
    chk("mul_req_msg", mul_req_msg, e_mreq_msg);
    chk("resp_val", resp_val, e_resp_val);
    chk("resp_msg", resp_msg, e_resp_msg);
    chk("mul_resp_rdy", mul_resp_rdy, e_mresp_rdy);
    chk("busy", busy, holder >= 0);
    chk("owner", owner, 2'(m_owner));
`ifdef PROC_IMUL_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("stat_grants", stat_grants[i*16 +: 16], 16'(g_cnt[i]));
    chk("stat_contention", stat_contention, 16'(c_cnt));
`endif
    fire_req = -1; fire_resp = 0; fire_owner = m_owner; fire_resp_msg = resp_msg;
    if (!inflight && $countones(req_val) > 1 && c_cnt < 65535) c_cnt++;
    if (inflight) begin
      if (mul_resp_val && resp_rdy[m_owner]) begin
        fire_resp = 1; inflight = 0; holder = -1; rr = (m_owner + 1) % N;
      end
    end else if (cand >= 0) begin
      m_owner = cand; holder = cand;
      if (req_val[cand] && mul_req_rdy) begin
        fire_req = cand; inflight = 1;
        if (g_cnt[cand] < 65535) g_cnt[cand]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_val", resp_val, '0);
    chk("rst_owner", owner, 2'd0);
    chk("rst_mul_resp_rdy", mul_resp_rdy, 1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_msg(input int i, input logic [31:0] a, input logic [31:0] b);
    req_msg[i*RW +: RW] = {a, b};
  endtask

  // Random-phase agents.
  bit            pend [N];
  logic [RW-1:0] rq_msg [N];
  logic [SW-1:0] rq_prod [N];
  bit            mbusy;
  int            mlat;
  logic [SW-1:0] mprod;

  initial begin
    reset = 1'b0; req_val = '0; req_msg = '0; resp_rdy = '0;
    mul_req_rdy = 1'b0; mul_resp_val = 1'b0; mul_resp_msg = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_busy", busy, 1'b0);
    chk("init_req_rdy", req_rdy, '0);
    chk("init_mul_req_val", mul_req_val, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Single requester: 6*7 returned after 3 cycles.
    req_val = 2'b01; set_msg(0, 32'd6, 32'd7); set_msg(1, 32'd3, 32'd5);
    mul_req_rdy = 1'b1; resp_rdy = 2'b11;
    #1 chk("single_mreq_msg", mul_req_msg, {32'd6, 32'd7});
    chk("single_req_rdy", req_rdy, 2'b01);
    tick();
    req_val = 2'b00;
    tick(); tick();
    mul_resp_val = 1'b1; mul_resp_msg = 32'd42;
    #1 chk("single_resp_val", resp_val, 2'b01);
    chk("single_resp_msg", resp_msg, 32'd42);
    tick();
    mul_resp_val = 1'b0; req_val = 2'b11;
    #1 chk("single_rr_next", req_rdy, 2'b10);
    tick();
    do_reset();

    // Contention: alternating grants with a mandatory idle cycle between transactions.
    req_val = 2'b11; mul_req_rdy = 1'b1; resp_rdy = 2'b11;
    for (int t = 0; t < 4; t++) begin
      #1 chk("cont_idle", busy, 1'b0);
      chk("cont_grant", req_rdy, (t % 2) ? 2'b10 : 2'b01);
      tick();
      mul_resp_val = 1'b1; mul_resp_msg = 32'(100 + t);
      #1 chk("cont_resp", resp_val, (t % 2) ? 2'b10 : 2'b01);
      chk("cont_no_req", mul_req_val, 1'b0);
      tick();
      mul_resp_val = 1'b0;
    end
    req_val = 2'b01;
    tick();
    mul_resp_val = 1'b1;
    tick();
    mul_resp_val = 1'b0; req_val = 2'b00;
`ifdef PROC_IMUL_ARB_STATS_EN
    #1 chk("stat_grants_lit", stat_grants, {16'd2, 16'd3});
    chk("stat_cont_lit", stat_contention, 16'd4);
`endif
    tick();
    do_reset();

    // Sticky grant: req1 held against req0 while the multiplier stalls.
    req_val = 2'b10; mul_req_rdy = 1'b0;
    tick();
    req_val = 2'b11;
    #1 chk("sticky_busy", busy, 1'b1);
    chk("sticky_blocked", req_rdy, 2'b00);
    chk("sticky_msg", mul_req_msg, {32'd3, 32'd5});
    tick();
    tick();
    mul_req_rdy = 1'b1;
    #1 chk("sticky_fire", req_rdy, 2'b10);
    tick();
    req_val = 2'b01;
    #1 chk("sticky_wait_owner", owner, 2'd1);

    // Response backpressure: owner not ready for five cycles.
    mul_resp_val = 1'b1; mul_resp_msg = 32'hABCD; resp_rdy = 2'b01;
    for (int t = 0; t < 5; t++) begin
      #1 chk("bp_mresp_rdy", mul_resp_rdy, 1'b0);
      chk("bp_busy", busy, 1'b1);
      tick();
    end
    resp_rdy = 2'b11;
    #1 chk("bp_release", mul_resp_rdy, 1'b1);
    chk("bp_msg", resp_msg, 32'hABCD);
    tick();

    // Spurious multiplier response while idle.
    req_val = 2'b00;
    #1 chk("spur_resp_val", resp_val, 2'b00);
    chk("spur_busy", busy, 1'b0);
    tick();

    // Reset in WAIT after one completed transaction moved the pointer to requester 1.
    mul_resp_val = 1'b0; req_val = 2'b01;
    tick();
    req_val = 2'b00; mul_resp_val = 1'b1;
    tick();
    mul_resp_val = 1'b0; req_val = 2'b10;
    tick();
    req_val = 2'b00; mul_resp_val = 1'b1; resp_rdy = 2'b00;
    #1 chk("rstw_busy", busy, 1'b1);
    do_reset();
    mul_resp_val = 1'b0; req_val = 2'b11; resp_rdy = 2'b11;
    #1 chk("rstw_rr_zero", req_rdy, 2'b01);
    tick();
    do_reset();

    // Randomized traffic.
    req_val = '0; mul_resp_val = 1'b0; mbusy = 0; mlat = 0; mprod = '0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; rq_msg[i] = '0; rq_prod[i] = '0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1; rq_msg[i] = {$urandom, $urandom};
        end
        req_val[i] = pend[i];
        req_msg[i*RW +: RW] = rq_msg[i];
      end
      resp_rdy = N'($urandom);
      mul_req_rdy = ($urandom_range(0, 2) != 0);
      if (mbusy) begin
        if (mlat > 0) begin mlat--; mul_resp_val = 1'b0; mul_resp_msg = $urandom; end
        else begin mul_resp_val = 1'b1; mul_resp_msg = mprod; end
      end else begin
        mul_resp_val = ($urandom_range(0, 7) == 0); mul_resp_msg = $urandom;
      end
      tick();
      if (fire_req >= 0) begin
        logic [31:0] a, b;
        a = rq_msg[fire_req][63:32]; b = rq_msg[fire_req][31:0];
        pend[fire_req] = 0;
        rq_prod[fire_req] = a * b;
        mprod = a * b; mbusy = 1; mlat = int'($urandom_range(0, 3));
      end
      if (fire_resp) begin
        chk("resp_data", fire_resp_msg, rq_prod[fire_owner]);
        mbusy = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
